int_wb_arbiter: RTL and testbench

//  Writeback stage directly downstream of the integer execute cluster.

---
 rtl/int_wb_arbiter_pkg.sv | 40 ++++
 rtl/int_wb_arbiter_slow_fifo.sv | 74 +++++++
 rtl/int_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_int_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_wb_arbiter_pkg.sv
// Shared types and constants for the integer writeback arbiter.
//   WbData       : one writeback record {rob_idx, we, rd, res}
//   loop_older   : age compare of two ROB indices that carry a wrap bit
//   wb_survives  : does a result survive the current redirect
package int_wb_arbiter_pkg;

  localparam int ROB_WIDTH     = 7;   // 6 index bits + wrap bit
  localparam int PREG_WIDTH    = 7;
  localparam int DATA_W        = 32;
  localparam int WB_ALU_NUM    = 4;
  localparam int MULT_SIZE     = 1;
  localparam int DIV_SIZE      = 1;
  localparam int WB_SLOW_NUM   = MULT_SIZE + DIV_SIZE;
  localparam int WB_PORT_NUM   = WB_ALU_NUM;
  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob_idx;
    logic                  we;
    logic [PREG_WIDTH-1:0] rd;
    logic [DATA_W-1:0]     res;
  } WbData;

  // a is strictly older than b. When the wrap bits differ, the older
  // entry is the one from the previous lap and so has the larger index.
  function automatic logic loop_older(input logic [ROB_WIDTH-1:0] a,
                                      input logic [ROB_WIDTH-1:0] b);
    logic same_lap;
    same_lap = (a[ROB_WIDTH-1] == b[ROB_WIDTH-1]);
    if (same_lap) return a[ROB_WIDTH-2:0] < b[ROB_WIDTH-2:0];
    else          return a[ROB_WIDTH-2:0] > b[ROB_WIDTH-2:0];
  endfunction

  function automatic logic wb_survives(input logic                 redirect,
                                       input logic [ROB_WIDTH-1:0] rob_idx,
                                       input logic [ROB_WIDTH-1:0] redirect_idx);
    return !redirect || loop_older(rob_idx, redirect_idx);
  endfunction

endpackage

// File: rtl/int_wb_arbiter_slow_fifo.sv
// Per-source result FIFO for the multiplier/divider writeback path.
//   push_i/push_data_i : enqueue (caller guarantees not full, already filtered)
//   pop_i              : dequeue head (only asserted while head_valid_o)
//   redirect_i/_idx_i  : squash entries younger than the redirect point
//   head_valid_o       : head exists and survives the current redirect
//   head_data_o        : head record
//   full_o             : no room; derived from pointers only
module int_wb_arbiter_slow_fifo
  import int_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  WbData                push_data_i,
  input  logic                 pop_i,
  input  logic                 redirect_i,
  input  logic [ROB_WIDTH-1:0] redirect_idx_i,
  output logic                 head_valid_o,
  output WbData                head_data_o,
  output logic                 full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count, keep_cnt, wr_base;
  logic [DEPTH-1:0] keep;
  logic [AW-1:0]    slot;
  logic             empty;
  WbData            mem_q [DEPTH];

  assign count  = wr_q - rd_q;
  assign empty  = (wr_q == rd_q);
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // keep[j] refers to the j-th oldest entry. Entries are age-ordered, so
  // the survivors always form a prefix and the write pointer can simply be
  // pulled back to rd + survivors; squashed entries vanish without a pop.
  always_comb begin
    keep     = '0;
    keep_cnt = '0;
    slot     = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot    = rd_q[AW-1:0] + AW'(j);
      keep[j] = ((AW+1)'(j) < count) &&
                wb_survives(redirect_i, mem_q[slot].rob_idx, redirect_idx_i);
      keep_cnt = keep_cnt + (AW+1)'(keep[j]);
    end
  end

  assign head_valid_o = !empty && keep[0];
  assign head_data_o  = mem_q[rd_q[AW-1:0]];

  assign wr_base = rd_q + keep_cnt;
  assign wr_d    = wr_base + (AW+1)'(push_i);
  assign rd_d    = rd_q + (AW+1)'(pop_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_base[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter downstream of the execute cluster.
// ALU i owns write port i and is never stalled. Mult/div results are
// buffered per source and fill ports left idle by the ALUs, served
// round-robin. A redirect squashes younger results at input and in buffers.
//   clk, rst               : clock, synchronous active-high reset
//   alu_valid/alu_data     : ALU results, one per write port
//   slow_valid/slow_data   : mult/div results (mult first, then div)
//   slow_ready             : per-source FIFO not full
//   redirect/redirect_idx  : backend redirect and its ROB index
//   wb_valid/wb_data       : registered regfile write / wakeup ports
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int ALU_NUM    = WB_ALU_NUM,
  parameter int SLOW_NUM   = WB_SLOW_NUM,
  parameter int WB_PORTS   = WB_PORT_NUM,   // must equal ALU_NUM
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALU_NUM-1:0]           alu_valid,
  input  WbData [ALU_NUM-1:0]          alu_data,
  input  logic [SLOW_NUM-1:0]          slow_valid,
  input  WbData [SLOW_NUM-1:0]         slow_data,
  output logic [SLOW_NUM-1:0]          slow_ready,
  input  logic                         redirect,
  input  logic [ROB_WIDTH-1:0]         redirect_idx,
  output logic [WB_PORTS-1:0]          wb_valid,
  output WbData [WB_PORTS-1:0]         wb_data
);

  localparam int RR_W = (SLOW_NUM > 1) ? $clog2(SLOW_NUM) : 1;

  logic [ALU_NUM-1:0]             alu_fire;
  logic [SLOW_NUM-1:0]            push, pop, head_valid, full;
  WbData [SLOW_NUM-1:0]           head_data;
  logic [WB_PORTS-1:0]            port_busy, sel_vld;
  logic [WB_PORTS-1:0][RR_W-1:0]  sel_src;
  logic [RR_W-1:0]                rr_q, rr_d;
  logic [WB_PORTS-1:0]            wb_valid_q, wb_valid_d;
  WbData [WB_PORTS-1:0]           wb_data_q, wb_data_d;
  int                             src;
  logic                           placed;

  always_comb begin
    for (int i = 0; i < ALU_NUM; i++)
      alu_fire[i] = alu_valid[i] &&
                    wb_survives(redirect, alu_data[i].rob_idx, redirect_idx);
  end

  always_comb begin
    for (int s = 0; s < SLOW_NUM; s++)
      push[s] = slow_valid[s] && !full[s] &&
                wb_survives(redirect, slow_data[s].rob_idx, redirect_idx);
  end

  assign slow_ready = ~full;

  for (genvar s = 0; s < SLOW_NUM; s++) begin : g_fifo
    int_wb_arbiter_slow_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push_i         (push[s]),
      .push_data_i    (slow_data[s]),
      .pop_i          (pop[s]),
      .redirect_i     (redirect),
      .redirect_idx_i (redirect_idx),
      .head_valid_o   (head_valid[s]),
      .head_data_o    (head_data[s]),
      .full_o         (full[s])
    );
  end

  // Walk sources in round-robin order from rr_q; each ready head takes the
  // lowest port not yet claimed by an ALU or an earlier grant, which makes
  // the k-th granted source land on the k-th free port.
  always_comb begin
    port_busy = alu_fire;
    sel_vld   = '0;
    sel_src   = '0;
    pop       = '0;
    rr_d      = rr_q;
    src       = 0;
    placed    = 1'b0;
    for (int k = 0; k < SLOW_NUM; k++) begin
      src    = (int'(rr_q) + k) % SLOW_NUM;
      placed = 1'b0;
      if (head_valid[src]) begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (!placed && !port_busy[p]) begin
            port_busy[p] = 1'b1;
            sel_vld[p]   = 1'b1;
            sel_src[p]   = RR_W'(src);
            pop[src]     = 1'b1;
            placed       = 1'b1;
            rr_d         = RR_W'((src + 1) % SLOW_NUM);
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_valid_d[p] = alu_fire[p] || sel_vld[p];
      wb_data_d[p]  = sel_vld[p] ? head_data[sel_src[p]] : alu_data[p];
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= '0;
      wb_data_q  <= '0;
      rr_q       <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      rr_q       <= rr_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_int_wb_arbiter.sv
module tb_int_wb_arbiter;
  import int_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_valid;
  WbData [3:0] alu_data;
  logic [1:0]  slow_valid;
  WbData [1:0] slow_data;
  logic [1:0]  slow_ready;
  logic        redirect;
  logic [6:0]  redirect_idx;
  logic [3:0]  wb_valid;
  WbData [3:0] wb_data;

  int total = 0;
  int bad   = 0;
  WbData exp_q [$];

  always #5 clk = ~clk;

  int_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_data     (alu_data),
    .slow_valid   (slow_valid),
    .slow_data    (slow_data),
    .slow_ready   (slow_ready),
    .redirect     (redirect),
    .redirect_idx (redirect_idx),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data)
  );

  typedef struct {
    logic [6:0] base;
    logic [3:0] av;
    logic       redir;
    logic [6:0] ridx;
    logic [3:0] ev;
  } vec_t;

  vec_t vecs [8];

  function automatic WbData mk(input logic [6:0] rob, input logic [6:0] rd,
                               input logic [31:0] res);
    WbData d;
    d.rob_idx = rob;
    d.we      = 1'b1;
    d.rd      = rd;
    d.res     = res;
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid    = '0;
    alu_data     = '0;
    slow_valid   = '0;
    slow_data    = '0;
    redirect     = 1'b0;
    redirect_idx = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alu_busy(input logic [6:0] base);
    alu_valid = 4'hF;
    for (int i = 0; i < 4; i++)
      alu_data[i] = mk(7'(base + 7'(i)), 7'(40 + i), 32'hC0DE_0000 + 32'(i));
  endtask

  // one mult push attempt; scoreboard entry recorded only if accepted
  task automatic mult_push(input WbData d, output logic acc);
    slow_valid[0] = 1'b1;
    slow_data[0]  = d;
    acc = slow_ready[0];
    if (acc) exp_q.push_back(d);
    tick();
    slow_valid[0] = 1'b0;
  endtask

  // each cycle the only free source is mult, so it lands on port 0
  task automatic drain_check(input string name, input int n);
    WbData e;
    for (int c = 0; c < n; c++) begin
      tick();
      chk({name, "_valid"}, 64'(wb_valid), 64'(4'b0001));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({name, "_data"}, 64'(wb_data[0]), 64'(e));
      end else begin
        chk({name, "_sb_empty"}, 64'(1), 64'(0));
      end
    end
  endtask

  initial begin
    logic  acc;
    int    k;
    WbData m, d, e;

    vecs[0] = '{7'h00, 4'hF, 1'b0, 7'h00, 4'hF};
    vecs[1] = '{7'h00, 4'h5, 1'b0, 7'h00, 4'h5};
    vecs[2] = '{7'h04, 4'hF, 1'b1, 7'h06, 4'h3};
    vecs[3] = '{7'h42, 4'hF, 1'b1, 7'h03, 4'hC};
    vecs[4] = '{7'h00, 4'h0, 1'b0, 7'h00, 4'h0};
    vecs[5] = '{7'h10, 4'h8, 1'b1, 7'h13, 4'h0};
    vecs[6] = '{7'h1E, 4'hF, 1'b1, 7'h21, 4'h7};
    vecs[7] = '{7'h7E, 4'hF, 1'b1, 7'h01, 4'h7};

    // 1: reset then idle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t1_wb_valid", 64'(wb_valid), 64'(0));
      chk("t1_ready", 64'(slow_ready), 64'(2'b11));
      chk("t1_wb_data0", 64'(wb_data[0]), 64'(0));
    end

    // 2: single ALU result, one cycle only
    alu_valid   = 4'b0001;
    alu_data[0] = mk(7'h00, 7'd5, 32'h0000_1234);
    tick();
    idle_inputs();
    chk("t2_valid", 64'(wb_valid), 64'(4'b0001));
    chk("t2_rd", 64'(wb_data[0].rd), 64'(5));
    chk("t2_res", 64'(wb_data[0].res), 64'(32'h1234));
    tick();
    chk("t2_valid_drop", 64'(wb_valid), 64'(0));

    // table: ALU path with survival filtering
    for (int v = 0; v < 8; v++) begin
      alu_valid    = vecs[v].av;
      redirect     = vecs[v].redir;
      redirect_idx = vecs[v].ridx;
      for (int i = 0; i < 4; i++)
        alu_data[i] = mk(7'(vecs[v].base + 7'(i)), 7'(v * 4 + i + 1),
                         32'hA000_0000 + 32'(v * 256 + i));
      tick();
      chk($sformatf("vec%0d_valid", v), 64'(wb_valid), 64'(vecs[v].ev));
      for (int i = 0; i < 4; i++)
        if (vecs[v].ev[i]) begin
          e = mk(7'(vecs[v].base + 7'(i)), 7'(v * 4 + i + 1),
                 32'hA000_0000 + 32'(v * 256 + i));
          chk($sformatf("vec%0d_data%0d", v, i), 64'(wb_data[i]), 64'(e));
        end
    end
    idle_inputs();

    // 3: ALUs saturate ports while mult fills its FIFO
    do_reset();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      alu_busy(7'h01);
      mult_push(mk(7'(10 + k), 7'(20 + k), 32'hBEEF_0000 + 32'(k)), acc);
      if (acc) k++;
      chk("t3_alu_only", 64'(wb_valid), 64'(4'hF));
      chk("t3_port0_alu", 64'(wb_data[0].res), 64'(32'hC0DE_0000));
    end
    chk("t3_accepted", 64'(k), 64'(4));
    chk("t3_ready_low", 64'(slow_ready[0]), 64'(0));
    idle_inputs();
    drain_check("t3_drain", 4);
    tick();
    chk("t3_idle", 64'(wb_valid), 64'(0));
    chk("t3_ready_back", 64'(slow_ready), 64'(2'b11));

    // 4: round-robin on a single free port
    do_reset();
    m = mk(7'h05, 7'd11, 32'h1111_0000);
    d = mk(7'h06, 7'd12, 32'h2222_0000);
    alu_busy(7'h01);
    slow_valid = 2'b11;
    slow_data  = {d, m};
    tick();
    slow_valid = 2'b00;
    chk("t4_ready", 64'(slow_ready), 64'(2'b11));
    alu_valid = 4'b1011;
    tick();
    chk("t4a_valid", 64'(wb_valid), 64'(4'hF));
    chk("t4a_mult_port2", 64'(wb_data[2]), 64'(m));
    chk("t4a_alu_port0", 64'(wb_data[0].res), 64'(32'hC0DE_0000));
    tick();
    chk("t4b_valid", 64'(wb_valid), 64'(4'hF));
    chk("t4b_div_port2", 64'(wb_data[2]), 64'(d));
    idle_inputs();
    tick();
    chk("t4_idle", 64'(wb_valid), 64'(0));

    // 5: redirect squashes younger FIFO entries and the incoming one
    do_reset();
    alu_busy(7'h01);
    mult_push(mk(7'd3, 7'd3, 32'h0000_0003), acc);
    mult_push(mk(7'd7, 7'd7, 32'h0000_0007), acc);
    mult_push(mk(7'd9, 7'd9, 32'h0000_0009), acc);
    redirect      = 1'b1;
    redirect_idx  = 7'd6;
    slow_valid[0] = 1'b1;
    slow_data[0]  = mk(7'd8, 7'd8, 32'h0000_0008);
    tick();
    chk("t5_redir_alu", 64'(wb_valid), 64'(4'hF));
    idle_inputs();
    exp_q.delete();
    tick();
    chk("t5_survivor_valid", 64'(wb_valid), 64'(4'b0001));
    chk("t5_survivor_rob", 64'(wb_data[0].rob_idx), 64'(3));
    tick();
    chk("t5_squashed", 64'(wb_valid), 64'(0));
    tick();
    chk("t5_squashed2", 64'(wb_valid), 64'(0));
    chk("t5_ready", 64'(slow_ready), 64'(2'b11));

    // 6: pointer wrap across three fill/drain rounds, reset mid-drain
    do_reset();
    for (int r = 0; r < 3; r++) begin
      alu_busy(7'h01);
      for (int j = 0; j < 4; j++)
        mult_push(mk(7'(r * 4 + j), 7'(r * 4 + j + 1), 32'h5000_0000 + 32'(r * 16 + j)), acc);
      chk($sformatf("t6_full_r%0d", r), 64'(slow_ready[0]), 64'(0));
      chk($sformatf("t6_queued_r%0d", r), 64'(exp_q.size()), 64'(4));
      idle_inputs();
      if (r < 2) drain_check("t6_drain", 4);
      else       drain_check("t6_drain_part", 2);
    end
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(wb_valid), 64'(0));
    chk("t6_rst_data", 64'(wb_data[0]), 64'(0));
    chk("t6_rst_ready", 64'(slow_ready), 64'(2'b11));
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_post_rst", 64'(wb_valid), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
